// File: rtl/word_tx_serializer.sv
// word_tx_serializer: sends a 32-bit readback word MSB-first as four UART byte handshakes
module word_tx_serializer #(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] data_in_32,
  input  logic        data_rdy,
  input  logic        tx_done,
  output logic [7:0]  tx_data_8,
  output logic        tx_start,
  output logic        busy,
  output logic        word_done,
  output logic        overrun,
  output logic        timeout_err
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, GAP, FIN} state_t;
  localparam logic [7:0]  GAP_LAST   = 8'(GAP_CYCLES - 1);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES);
  localparam state_t      AFTER_DONE = (GAP_CYCLES == 0) ? LOAD : GAP;
  state_t      state, state_n;
  logic        rdy_q, rdy_edge, done_ok;
  logic [31:0] shift_reg, shift_n;
  logic [1:0]  byte_cnt, byte_cnt_n;
  logic [15:0] tmo_cnt, tmo_n;
  logic [7:0]  gap_cnt, gap_n, tx_data_n;
  logic        tx_start_n, busy_n, word_done_n, overrun_n, timeout_n;
  assign rdy_edge = data_rdy & ~rdy_q;
  assign done_ok  = tx_done & ~tx_start;
  always_comb begin
    state_n     = state;
    shift_n     = shift_reg;
    byte_cnt_n  = byte_cnt;
    tmo_n       = tmo_cnt;
    gap_n       = gap_cnt;
    tx_data_n   = tx_data_8;
    tx_start_n  = 1'b0;
    word_done_n = 1'b0;
    timeout_n   = 1'b0;
    overrun_n   = rdy_edge && (state != IDLE);
    case (state)
      IDLE: if (rdy_edge) begin
        shift_n    = data_in_32;
        byte_cnt_n = 2'd0;
        state_n    = LOAD;
      end
      LOAD: begin
        tx_data_n  = shift_reg[31:24];
        shift_n    = {shift_reg[23:0], 8'h00};
        tx_start_n = 1'b1;
        tmo_n      = 16'd0;
        state_n    = WAIT;
      end
      WAIT: if (done_ok) begin
        state_n    = (byte_cnt == 2'd3) ? FIN : AFTER_DONE;
        byte_cnt_n = (byte_cnt == 2'd3) ? byte_cnt : byte_cnt + 2'd1;
        gap_n      = 8'd0;
      end else if (tmo_cnt == TMO_LAST) begin
        timeout_n = 1'b1;
        state_n   = IDLE;
      end else begin
        tmo_n = tmo_cnt + 16'd1;
      end
      GAP: begin
        state_n = (gap_cnt == GAP_LAST) ? LOAD : GAP;
        gap_n   = (gap_cnt == GAP_LAST) ? gap_cnt : gap_cnt + 8'd1;
      end
      FIN: begin
        word_done_n = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE) || (state == FIN);
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      rdy_q       <= 1'b0;
      shift_reg   <= 32'd0;
      byte_cnt    <= 2'd0;
      tmo_cnt     <= 16'd0;
      gap_cnt     <= 8'd0;
      tx_data_8   <= 8'h00;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      word_done   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      rdy_q       <= data_rdy;
      shift_reg   <= shift_n;
      byte_cnt    <= byte_cnt_n;
      tmo_cnt     <= tmo_n;
      gap_cnt     <= gap_n;
      tx_data_8   <= tx_data_n;
      tx_start    <= tx_start_n;
      busy        <= busy_n;
      word_done   <= word_done_n;
      overrun     <= overrun_n;
      timeout_err <= timeout_n;
    end
  end
endmodule

// File: tb/tb_word_tx_serializer.sv
// tb_word_tx_serializer: vector table plus scoreboard bench for the word serializer (GAP=2 and GAP=0 instances)
module tb_word_tx_serializer;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] din_a, din_b;
  logic rdy_a, rdy_b, done_a, done_b;
  logic [7:0] txd_a, txd_b;
  logic txs_a, busy_a, wd_a, ovr_a, tmo_a;
  logic txs_b, busy_b, wd_b, ovr_b, tmo_b;
  int checks = 0, errors = 0;
  int st_cnt = 0, wd_cnt = 0, ovr_cnt = 0, tmo_cnt = 0;
  int rdy_left = 0;
  bit uart_en = 1'b1;
  logic [7:0] exp_q[$];
  typedef struct {
    logic [31:0]     word;
    int              hold;
    logic [3:0][7:0] b;
  } vec_t;
  vec_t vecs[4];
  always #5 clk = ~clk;
  word_tx_serializer #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(50)) dut_a (
    .Clk(clk), .Reset(reset), .data_in_32(din_a), .data_rdy(rdy_a), .tx_done(done_a),
    .tx_data_8(txd_a), .tx_start(txs_a), .busy(busy_a), .word_done(wd_a),
    .overrun(ovr_a), .timeout_err(tmo_a)
  );
  word_tx_serializer #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(50)) dut_b (
    .Clk(clk), .Reset(reset), .data_in_32(din_b), .data_rdy(rdy_b), .tx_done(done_b),
    .tx_data_8(txd_b), .tx_start(txs_b), .busy(busy_b), .word_done(wd_b),
    .overrun(ovr_b), .timeout_err(tmo_b)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      if (txs_a) begin
        st_cnt++;
        chk("busy_at_start", busy_a, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_tx_start: byte %0h sent with no byte expected", txd_a);
        end else chk("tx_byte", txd_a, exp_q.pop_front());
      end
      if (wd_a) wd_cnt++;
      if (ovr_a) ovr_cnt++;
      if (tmo_a) tmo_cnt++;
    end
  end
  initial begin
    done_a = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (txs_a && uart_en && reset) begin
        repeat (19) @(posedge clk);
        #1 done_a = reset;
        @(posedge clk);
        #1 done_a = 1'b0;
      end
    end
  end
  initial begin
    forever begin
      @(posedge clk); #2;
      if (rdy_left > 0) begin
        rdy_left--;
        if (rdy_left == 0) rdy_a = 1'b0;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
    $fatal(1);
  end
  task automatic send(input logic [31:0] w, input int h);
    @(posedge clk); #1;
    din_a = w;
    rdy_a = 1'b1;
    rdy_left = h + 1;
  endtask
  task automatic wait_start(input string name);
    int t = 0;
    while (!txs_a && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, txs_a, 1);
    @(negedge clk);
  endtask
  task automatic apply_vec(input int i);
    int s_wd, s_ovr, s_st, s_tmo, t;
    s_wd = wd_cnt; s_ovr = ovr_cnt; s_st = st_cnt; s_tmo = tmo_cnt;
    for (int k = 3; k >= 0; k--) exp_q.push_back(vecs[i].b[k]);
    send(vecs[i].word, vecs[i].hold);
    @(negedge clk);
    chk("busy_before_edge", busy_a, 0);
    @(negedge clk);
    chk("busy_latency", busy_a, 1);
    chk("start_not_yet", txs_a, 0);
    @(negedge clk);
    chk("start_latency", txs_a, 1);
    t = 0;
    while (!wd_a && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("word_done_seen", wd_a, 1);
    chk("busy_at_done", busy_a, 1);
    @(negedge clk);
    chk("busy_after_done", busy_a, 0);
    chk("word_done_pulse", wd_a, 0);
    chk("start_count", st_cnt - s_st, 4);
    chk("overrun_count", ovr_cnt - s_ovr, 0);
    chk("done_count", wd_cnt - s_wd, 1);
    chk("timeout_count", tmo_cnt - s_tmo, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask
  initial begin
    int s_wd, s_ovr, s_st, t, n, act;
    logic [7:0] bexp[4];
    vecs[0] = '{32'hDEADBEEF, 1, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
    vecs[1] = '{32'h12345678, 8, {8'h12, 8'h34, 8'h56, 8'h78}};
    vecs[2] = '{32'h0000FFFF, 2, {8'h00, 8'h00, 8'hFF, 8'hFF}};
    vecs[3] = '{32'h80000001, 3, {8'h80, 8'h00, 8'h00, 8'h01}};
    bexp = '{8'h0A, 8'hB0, 8'hC3, 8'h5D};
    reset = 1'b0;
    din_a = 32'd0; rdy_a = 1'b0;
    din_b = 32'd0; rdy_b = 1'b0; done_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", txd_a, 0);
    chk("rst_tx_start", txs_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_word_done", wd_a, 0);
    chk("rst_overrun", ovr_a, 0);
    chk("rst_timeout", tmo_a, 0);
    chk("rst_b_busy", busy_b, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) apply_vec(i);
    s_wd = wd_cnt; s_ovr = ovr_cnt; s_st = st_cnt;
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    send(32'h01020304, 1);
    wait_start("ovr_first_start");
    wait_start("ovr_second_start");
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    din_a = 32'hCAFEF00D;
    rdy_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("overrun_pulse", ovr_a, 1);
    chk("busy_during_overrun", busy_a, 1);
    @(posedge clk); #1;
    rdy_a = 1'b0;
    @(negedge clk);
    chk("overrun_one_cycle", ovr_a, 0);
    t = 0;
    while (!wd_a && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("ovr_word_done", wd_a, 1);
    repeat (60) @(negedge clk);
    chk("ovr_count", ovr_cnt - s_ovr, 1);
    chk("ovr_start_count", st_cnt - s_st, 4);
    chk("ovr_done_count", wd_cnt - s_wd, 1);
    chk("ovr_queue", exp_q.size(), 0);
    s_wd = wd_cnt;
    uart_en = 1'b0;
    exp_q.push_back(8'h11);
    send(32'h11223344, 1);
    t = 0;
    while (!txs_a && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("tmo_start", txs_a, 1);
    n = 0;
    while (!tmo_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n, 51);
    chk("busy_at_timeout", busy_a, 0);
    @(negedge clk);
    chk("timeout_one_cycle", tmo_a, 0);
    repeat (20) @(negedge clk);
    chk("tmo_no_word_done", wd_cnt - s_wd, 0);
    chk("tmo_queue", exp_q.size(), 0);
    uart_en = 1'b1;
    apply_vec(3);
    s_wd = wd_cnt;
    for (int k = 0; k < 4; k++) exp_q.push_back(8'hA5);
    send(32'hA5A5A5A5, 1);
    wait_start("rst_first_start");
    wait_start("rst_second_start");
    repeat (20) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_tx_data", txd_a, 0);
    chk("abort_tx_start", txs_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_word_done", wd_a, 0);
    chk("abort_overrun", ovr_a, 0);
    chk("abort_timeout", tmo_a, 0);
    chk("abort_unsent_bytes", exp_q.size(), 2);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_word_done", wd_cnt - s_wd, 0);
    apply_vec(2);
    @(posedge clk); #1;
    din_b = 32'h0AB0C35D;
    rdy_b = 1'b1;
    @(posedge clk); #1;
    rdy_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!txs_b && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("gap0_start", txs_b, 1);
      chk("gap0_byte", txd_b, bexp[i]);
      @(posedge clk); #1;
      done_b = 1'b1;
      @(posedge clk); #1;
      done_b = 1'b0;
      @(negedge clk);
      chk("gap0_no_early_start", txs_b, 0);
      @(negedge clk);
      if (i < 3) chk("gap0_latency", txs_b, 1);
      else chk("gap0_word_done", wd_b, 1);
    end
    repeat (3) @(posedge clk);
    #1 done_b = 1'b1;
    @(posedge clk);
    #1 done_b = 1'b0;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      act += int'(txs_b | wd_b | ovr_b | tmo_b | busy_b);
    end
    chk("stray_done_quiet", act, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/word_tx_serializer.md
# word_tx_serializer

Converts one 32-bit readback word into four UART bytes for the debug link back to the host. It sits between the address/data readback multiplexer, which supplies `data_out_32` and a `data_rdy` level, and the byte-wide UART transmitter. Each `data_rdy` rising edge sends the word MSB-first as four `tx_start`/`tx_done` handshakes, with a programmable inter-byte gap and a per-byte timeout.

## Interface
- `GAP_CYCLES`, default 2: idle clocks between a `tx_done` and the next `tx_start` (0..255).
- `TIMEOUT_CYCLES`, default 65535: maximum clocks to wait for `tx_done` per byte (1..65535).
- `Clk`  in  1  system clock; all logic is rising-edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `data_in_32`  in  32  word to transmit; sampled only on the accepting edge.
- `data_rdy`  in  1  request level from the readback mux; may stay high for several clocks.
- `tx_done`  in  1  one-clock pulse from the UART transmitter when a byte's stop bit completes.
- `tx_data_8`  out  8  byte to transmit; registered and stable from `tx_start` until the next load.
- `tx_start`  out  1  one-clock pulse that launches the UART transmitter.
- `busy`  out  1  high from word accept until word completion or abort.
- `word_done`  out  1  one-clock pulse after the fourth byte's `tx_done`.
- `overrun`  out  1  one-clock pulse when a `data_rdy` rising edge arrives while busy.
- `timeout_err`  out  1  one-clock pulse when a byte times out; the word is abandoned.

## Operation
- Edge detect:
  - `rdy_q` is a registered copy of `data_rdy`.
  - `rdy_edge = data_rdy & ~rdy_q`.
  - Only edges start transfers; a held level never retriggers.
- States are IDLE, LOAD, WAIT, GAP and FIN.
- IDLE:
  - On `rdy_edge`, latch `data_in_32` into `shift_reg`, clear `byte_cnt` (2-bit) and go to LOAD.
  - `busy` rises on this edge.
- LOAD:
  - Drive `tx_data_8 <= shift_reg[31:24]`, `shift_reg <= shift_reg << 8` and `tx_start <= 1`.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - `tx_start` returns to 0 after one clock.
  - `tx_done` is honored only while `tx_start` is 0.
  - On `tx_done` with `byte_cnt == 3`, go to FIN.
  - On `tx_done` otherwise, increment `byte_cnt` and go to GAP. If `GAP_CYCLES == 0`, go directly to LOAD instead.
  - If the 16-bit timeout counter reaches `TIMEOUT_CYCLES`:
    - pulse `timeout_err`;
    - clear `busy`;
    - go to IDLE;
    - leave the remaining bytes unsent.
- GAP: count `GAP_CYCLES` clocks (8-bit counter), then go to LOAD.
- FIN: pulse `word_done`, clear `busy` and go to IDLE.
- `overrun`:
  - A `rdy_edge` in any state other than IDLE pulses `overrun` and is dropped.
  - The word in flight continues unaffected.
- Stray pulses: `tx_done` in IDLE, LOAD, GAP or FIN is ignored.
- Byte order: `data_in_32[31:24]`, then `[23:16]`, then `[15:8]`, then `[7:0]`.

## Timing
- Reset (async assert, sync release):
  - `tx_data_8 = 8'h00`;
  - `tx_start`, `busy`, `word_done`, `overrun`, `timeout_err` all 0;
  - state IDLE, `rdy_q = 0`, all counters 0.
- Reset asserted mid-word aborts immediately. No `word_done` or `timeout_err` is generated.
- If `data_rdy` is high when `Reset` releases, it counts as an edge on the first clock, because `rdy_q` resets to 0.
- Latency:
  - `data_rdy` is first seen high at edge N;
  - `busy` is 1 after edge N;
  - `tx_start` is 1 for the cycle after edge N+1.
- `tx_done` seen at edge M leads to the next `tx_start` being high after edge M+GAP_CYCLES+1. GAP_CYCLES=0 gives M+1.
- The final `tx_done` at edge M leads to `word_done` high after edge M+1 and `busy` low after edge M+2.
- Timeout:
  - `timeout_err` is high for exactly one cycle, TIMEOUT_CYCLES+1 clocks after the `tx_start` cycle.
  - `busy` falls on the same edge.
- Same-edge priority in IDLE: a `rdy_edge` is accepted even if `tx_done` is also high.
- Same-edge priority in WAIT: if `tx_done` and the timeout hit coincide, `tx_done` wins.

## Test plan
- Word 32'hDEADBEEF, UART model answering `tx_done` 20 clocks after each `tx_start`, GAP=2 -> bytes DE, AD, BE, EF in order; four `tx_start` pulses; one `word_done`; `busy` high throughout.
- `data_rdy` held high 8 clocks with 32'h12345678 -> exactly one four-byte transfer; `overrun` never asserts.
- Second `data_rdy` edge with 32'hCAFEF00D during byte 2 of 32'h01020304 -> `overrun` pulses once; bytes are 01, 02, 03, 04 only; no fifth `tx_start`.
- TIMEOUT_CYCLES=50 and the UART model never answers byte 1 -> `timeout_err` pulses 51 clocks after the first `tx_start`; `busy` goes 0; a new word then transmits normally.
- `Reset` pulled low after byte 2 of 32'hA5A5A5A5 -> all outputs read 0 immediately; no `word_done`; after release, 32'h0000FFFF sends 00, 00, FF, FF.
- GAP_CYCLES=0 -> each `tx_start` is exactly 1 clock after the preceding `tx_done`; a stray `tx_done` in IDLE produces no output activity.
